// File: rtl/ntt_mem_pkg.sv
// Shared types and default sizes for the NTT coefficient BRAM arbiter.
// Optional feature macro used by the top level: BRAM_WR_FWD_EN.
package ntt_mem_pkg;

    localparam int NTT_ADDR_W = 7;
    localparam int NTT_DATA_W = 24;
    localparam int NTT_RD_LAT = 1;

    // Requester index: 0 = NTT butterfly engine, 1 = load/unload DMA.
    typedef logic req_id_t;

    // Tag carried alongside each granted read until its data returns.
    typedef struct packed {
        logic                  valid;
        req_id_t               id;
        logic                  fwd;
        logic [NTT_DATA_W-1:0] fwd_data;
    } rsp_tag_t;

endpackage

// File: rtl/ntt_bram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit preference pointer.
// After any grant the pointer moves to the requester that was not served.
module rr_arb2
    import ntt_mem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    req_id_t    r_prio;
    logic [1:0] w_grant;

    // Pick a winner: a lone requester always wins, a tie goes to r_prio.
    always_comb begin
        w_grant = 2'b00;
        if (!i_reset) begin
            unique case (i_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign o_grant = w_grant;

    // Prefer the other requester once this one has been served.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prio <= 1'b0;
        end else if (|w_grant) begin
            r_prio <= w_grant[0];
        end
    end

endmodule

// File: rtl/ntt_bram_arbiter.sv
// Shares one simple-dual-port coefficient BRAM between the NTT engine and the DMA.
// Define BRAM_WR_FWD_EN to forward same-cycle same-address write data to the read.
module ntt_bram_arbiter
    import ntt_mem_pkg::*;
#(
    parameter int ADDR_W = NTT_ADDR_W,
    parameter int DATA_W = NTT_DATA_W,
    parameter int RD_LAT = NTT_RD_LAT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [1:0]          i_wr_valid,
    output logic [1:0]          o_wr_ready,
    input  logic [2*ADDR_W-1:0] i_wr_addr,
    input  logic [2*DATA_W-1:0] i_wr_data,
    input  logic [1:0]          i_rd_valid,
    output logic [1:0]          o_rd_ready,
    input  logic [2*ADDR_W-1:0] i_rd_addr,
    output logic [1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]   o_rsp_data,
    output logic                o_bram_wea,
    output logic [ADDR_W-1:0]   o_bram_addra,
    output logic [DATA_W-1:0]   o_bram_dina,
    output logic                o_bram_enb,
    output logic [ADDR_W-1:0]   o_bram_addrb,
    input  logic [DATA_W-1:0]   i_bram_doutb
);

    req_id_t           w_wr_id;
    req_id_t           w_rd_id;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_fwd_hit;
    rsp_tag_t          w_tail;
    rsp_tag_t          r_pipe [RD_LAT];

    rr_arb2 u_wr_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_wr_valid),
        .o_grant (o_wr_ready)
    );

    rr_arb2 u_rd_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_rd_valid),
        .o_grant (o_rd_ready)
    );

    // Steer the granted requester's address/data onto the BRAM ports.
    always_comb begin
        w_wr_id   = o_wr_ready[1];
        w_rd_id   = o_rd_ready[1];
        w_wr_addr = w_wr_id ? i_wr_addr[ADDR_W +: ADDR_W]
                            : i_wr_addr[0 +: ADDR_W];
        w_wr_data = w_wr_id ? i_wr_data[DATA_W +: DATA_W]
                            : i_wr_data[0 +: DATA_W];
        w_rd_addr = w_rd_id ? i_rd_addr[ADDR_W +: ADDR_W]
                            : i_rd_addr[0 +: ADDR_W];
`ifdef BRAM_WR_FWD_EN
        w_fwd_hit = (|o_wr_ready) && (|o_rd_ready)
                 && (w_wr_addr == w_rd_addr);
`else
        w_fwd_hit = 1'b0;
`endif
    end

    assign o_bram_wea   = |o_wr_ready;
    assign o_bram_addra = w_wr_addr;
    assign o_bram_dina  = w_wr_data;
    assign o_bram_enb   = |o_rd_ready;
    assign o_bram_addrb = w_rd_addr;

    // Age each granted read's tag in step with the BRAM read latency.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0].valid    <= |o_rd_ready;
            r_pipe[0].id       <= w_rd_id;
            r_pipe[0].fwd      <= w_fwd_hit;
            r_pipe[0].fwd_data <= w_wr_data;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail = r_pipe[RD_LAT-1];

    // Route the oldest tag to its requester; captured write data wins on a hit.
    always_comb begin
        o_rsp_valid = 2'b00;
        if (w_tail.valid) begin
            o_rsp_valid[w_tail.id] = 1'b1;
        end
        o_rsp_data = w_tail.fwd ? w_tail.fwd_data : i_bram_doutb;
    end

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Bench for ntt_bram_arbiter: two instances (read latency 1 and 3) share stimulus.
// Each instance drives its own behavioural BRAM; a queue model predicts responses.
module tb_ntt_bram_arbiter;

    localparam int AW = 7;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    wv, rv;
    logic [2*AW-1:0] wa, ra;
    logic [2*DW-1:0] wd;

    logic [1:0]    wr_rdy1, rd_rdy1, rsp_v1, wr_rdy3, rd_rdy3, rsp_v3;
    logic [DW-1:0] rsp_d1, dina1, rsp_d3, dina3, doutb3;
    logic [DW-1:0] doutb1 = '0;
    logic          wea1, enb1, wea3, enb3;
    logic [AW-1:0] addra1, addrb1, addra3, addrb3;

    ntt_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_reset(reset),
        .i_wr_valid(wv), .o_wr_ready(wr_rdy1), .i_wr_addr(wa), .i_wr_data(wd),
        .i_rd_valid(rv), .o_rd_ready(rd_rdy1), .i_rd_addr(ra),
        .o_rsp_valid(rsp_v1), .o_rsp_data(rsp_d1),
        .o_bram_wea(wea1), .o_bram_addra(addra1), .o_bram_dina(dina1),
        .o_bram_enb(enb1), .o_bram_addrb(addrb1), .i_bram_doutb(doutb1)
    );

    ntt_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
        .i_clk(clk), .i_reset(reset),
        .i_wr_valid(wv), .o_wr_ready(wr_rdy3), .i_wr_addr(wa), .i_wr_data(wd),
        .i_rd_valid(rv), .o_rd_ready(rd_rdy3), .i_rd_addr(ra),
        .o_rsp_valid(rsp_v3), .o_rsp_data(rsp_d3),
        .o_bram_wea(wea3), .o_bram_addra(addra3), .o_bram_dina(dina3),
        .o_bram_enb(enb3), .o_bram_addrb(addrb3), .i_bram_doutb(doutb3)
    );

    // Read-first BRAMs: one output register, or three pipeline registers.
    logic [DW-1:0] mem1 [128] = '{default: '0};
    logic [DW-1:0] mem3 [128] = '{default: '0};
    logic [DW-1:0] p3 [3] = '{default: '0};
    always @(posedge clk) begin
        if (wea1) mem1[addra1] <= dina1;
        if (enb1) doutb1 <= mem1[addrb1];
        if (wea3) mem3[addra3] <= dina3;
        if (enb3) p3[0] <= mem3[addrb3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign doutb3 = p3[2];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [1:0] wv, rv, ew, er;
    } vec_t;

    exp_t          q1[$], q3[$];
    logic [DW-1:0] m_mem [128] = '{default: '0};
    bit            m_pw, m_pr;
    int            cyc, checks, fails;
    int            wait_w[2], wait_r[2];
    logic [1:0]    hs_w, hs_r;
    int            n_rsp0_1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    // A lone requester wins; on a tie the preferred one wins.
    function automatic logic [1:0] rr_pick(logic [1:0] v, bit pref);
        if (v == 2'b11) return pref ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_step();
        logic [1:0]    ew, er;
        logic [AW-1:0] a;
        int            iw, ir;
        exp_t          e;
        if (reset) begin
            chk("rst_wr_ready", {wr_rdy3, wr_rdy1}, 0);
            chk("rst_rd_ready", {rd_rdy3, rd_rdy1}, 0);
            chk("rst_wea_enb", {wea3, enb3, wea1, enb1}, 0);
            chk("rst_rsp_valid", {rsp_v3, rsp_v1}, 0);
            q1.delete(); q3.delete();
            m_pw = 0; m_pr = 0;
            wait_w = '{0, 0}; wait_r = '{0, 0};
            hs_w = 0; hs_r = 0;
            return;
        end
        ew = rr_pick(wv, m_pw);
        er = rr_pick(rv, m_pr);
        chk("wr_ready1", wr_rdy1, ew);
        chk("wr_ready3", wr_rdy3, ew);
        chk("rd_ready1", rd_rdy1, er);
        chk("rd_ready3", rd_rdy3, er);
        chk("wea", {wea3, wea1}, {2{|ew}});
        chk("enb", {enb3, enb1}, {2{|er}});
        iw = (ew == 2'b10) ? 1 : 0;
        ir = (er == 2'b10) ? 1 : 0;
        if (ew != 0) begin
            chk("addra", addra1, wa[iw*AW +: AW]);
            chk("dina", dina1, wd[iw*DW +: DW]);
        end
        if (er != 0) chk("addrb", addrb1, ra[ir*AW +: AW]);

        if (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            chk("rsp_valid1", rsp_v1, 2'b01 << e.id);
            chk("rsp_data1", rsp_d1, e.data);
        end else chk("rsp_valid1", rsp_v1, 2'b00);
        if (q3.size() > 0 && q3[0].due <= cyc) begin
            e = q3.pop_front();
            chk("rsp_valid3", rsp_v3, 2'b01 << e.id);
            chk("rsp_data3", rsp_d3, e.data);
        end else chk("rsp_valid3", rsp_v3, 2'b00);
        if (rsp_v1[0]) n_rsp0_1++;

        if (er != 0) begin
            a = ra[ir*AW +: AW];
            e.id = ir[0];
            e.data = m_mem[a];
`ifdef BRAM_WR_FWD_EN
            if (ew != 0 && wa[iw*AW +: AW] == a) e.data = wd[iw*DW +: DW];
`endif
            e.due = cyc + 1; q1.push_back(e);
            e.due = cyc + 3; q3.push_back(e);
            m_pr = (ir == 0);
        end
        if (ew != 0) begin
            m_mem[wa[iw*AW +: AW]] = wd[iw*DW +: DW];
            m_pw = (iw == 0);
        end

        for (int i = 0; i < 2; i++) begin
            wait_w[i] = (wv[i] && !wr_rdy1[i]) ? wait_w[i] + 1 : 0;
            wait_r[i] = (rv[i] && !rd_rdy1[i]) ? wait_r[i] + 1 : 0;
            if (wait_w[i] > 0) chk("wr_wait", wait_w[i] <= 1, 1);
            if (wait_r[i] > 0) chk("rd_wait", wait_r[i] <= 1, 1);
        end
        hs_w = wv & wr_rdy1;
        hs_r = rv & rd_rdy1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        wv = 0; rv = 0;
        repeat (n) begin sample(); advance(); end
    endtask

    vec_t vt [9];
    int   base;

    initial begin
        checks = 0; fails = 0; cyc = 0; n_rsp0_1 = 0;
        wait_w = '{0, 0}; wait_r = '{0, 0};
        hs_w = 0; hs_r = 0;
        reset = 0; wv = 0; rv = 0; wa = '0; ra = '0; wd = '0;
        #2 reset = 1;
        repeat (3) begin sample(); advance(); end
        reset = 0;

        // Arbitration table, starting from both pointers at requester 0.
        vt[0] = '{2'b11, 2'b00, 2'b01, 2'b00};
        vt[1] = '{2'b11, 2'b11, 2'b10, 2'b01};
        vt[2] = '{2'b01, 2'b11, 2'b01, 2'b10};
        vt[3] = '{2'b00, 2'b10, 2'b00, 2'b10};
        vt[4] = '{2'b11, 2'b11, 2'b10, 2'b01};
        vt[5] = '{2'b10, 2'b01, 2'b10, 2'b01};
        vt[6] = '{2'b11, 2'b11, 2'b01, 2'b10};
        vt[7] = '{2'b00, 2'b00, 2'b00, 2'b00};
        vt[8] = '{2'b11, 2'b11, 2'b10, 2'b01};
        wa = {7'd21, 7'd20}; ra = {7'd21, 7'd20};
        for (int i = 0; i < 9; i++) begin
            wv = vt[i].wv; rv = vt[i].rv;
            wd = {24'h210000 + 24'(i), 24'h200000 + 24'(i)};
            sample();
            chk("tbl_wr_ready", wr_rdy1, vt[i].ew);
            chk("tbl_rd_ready", rd_rdy1, vt[i].er);
            advance();
        end
        idle(4);

        // Reset with a read one cycle earlier, valids held high through it.
        rv = 2'b01; ra = {7'd0, 7'd7};
        sample(); advance();
        reset = 1; wv = 2'b11; rv = 2'b11;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_rsp1", rsp_v1, 2'b00);
            chk("rst_rsp3", rsp_v3, 2'b00);
            chk("rst_bram_en", {wea1, enb1}, 2'b00);
            advance();
        end
        reset = 0;
        wa = {7'd9, 7'd5}; wd = {24'hABCDEF, 24'h000555};
        ra = {7'd2, 7'd1};
        sample();
        chk("post_rst_wr", wr_rdy1, 2'b01);
        chk("post_rst_rd", {rd_rdy3, rd_rdy1}, 4'b0101);
        chk("post_rst_rsp3", rsp_v3, 2'b00);
        advance();
        rv = 2'b00;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("wr_contend", wr_rdy1, (i % 2 == 0) ? 2'b10 : 2'b01);
            advance();
        end
        idle(4);

        // Single read of address 9 by requester 1.
        rv = 2'b10; ra = {7'd9, 7'd0};
        sample(); chk("rd9_ready", rd_rdy1, 2'b10); advance();
        rv = 2'b00;
        sample();
        chk("rd9_v1", rsp_v1, 2'b10);
        chk("rd9_d1", rsp_d1, 24'hABCDEF);
        chk("rd9_v3_early", rsp_v3, 2'b00);
        advance();
        sample(); chk("rd9_v3_early", rsp_v3, 2'b00); advance();
        sample();
        chk("rd9_v3", rsp_v3, 2'b10);
        chk("rd9_d3", rsp_d3, 24'hABCDEF);
        advance();
        idle(2);

        // Fill memory, then stream reads 0..127 and wrap.
        for (int i = 0; i < 128; i++) begin
            wv = 2'b10;
            wa = {7'(i), 7'd0};
            wd = {24'h300000 + 24'(i * 5), 24'h0};
            sample(); chk("fill_ready", wr_rdy1, 2'b10); advance();
        end
        wv = 0;
        base = n_rsp0_1;
        for (int i = 0; i < 130; i++) begin
            rv = 2'b01;
            ra = {7'd0, 7'(i % 128)};
            sample(); chk("stream_ready", rd_rdy1, 2'b01); advance();
        end
        idle(4);
        chk("stream_count", n_rsp0_1 - base, 130);

        // Same-cycle write and read of address 3.
        wv = 2'b10; wa = {7'd3, 7'd0}; wd = {24'h123456, 24'h0};
        rv = 2'b01; ra = {7'd0, 7'd3};
        sample();
        chk("col_ready", {wr_rdy1, rd_rdy1}, 4'b1001);
        advance();
        wv = 0; rv = 0;
        sample();
        chk("col_v1", rsp_v1, 2'b01);
`ifdef BRAM_WR_FWD_EN
        chk("col_d1", rsp_d1, 24'h123456);
`endif
        advance();
        sample(); advance();
        sample();
        chk("col_v3", rsp_v3, 2'b01);
`ifdef BRAM_WR_FWD_EN
        chk("col_d3", rsp_d3, 24'h123456);
`endif
        advance();
        idle(3);

        // Random traffic; requesters hold their request until accepted.
        hs_w = 0; hs_r = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!wv[i] || hs_w[i]) begin
                    wv[i] = ($urandom % 3) != 0;
                    wa[i*AW +: AW] = ($urandom % 4 == 0) ? 7'($urandom)
                                                        : 7'($urandom % 8);
                    wd[i*DW +: DW] = 24'($urandom);
                end
                if (!rv[i] || hs_r[i]) begin
                    rv[i] = ($urandom % 3) != 0;
                    ra[i*AW +: AW] = ($urandom % 4 == 0) ? 7'($urandom)
                                                        : 7'($urandom % 8);
                end
            end
            sample(); advance();
        end
        idle(5);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q3", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
